display_scan_ctrl: RTL
======================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 100000: clocks each digit is driven per slot; legal values >=1.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000: clocks all anodes are off before each digit slot (anti-ghosting); legal values >=1.
REQ-003 SHALL have port i_Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_Data, input, 16 bits: four hex nibbles; digit n = i_Data[4n+3:4n].
REQ-006 SHALL have port i_Load, input, 1 bit: load request; accepted when i_Load & o_Ready.
REQ-007 SHALL have port o_Ready, output, 1 bit: shadow register free.
REQ-008 SHALL have port i_DigitEn, input, 4 bits: per-digit enable, sampled live.
REQ-009 SHALL have port i_Dp, input, 4 bits: per-digit decimal point, active-high, sampled live.
REQ-010 SHALL have port o_Sel, output, 2 bits: index of the current digit slot.
REQ-011 SHALL have port o_Anodos, output, 4 bits: one-cold anode drive; bit n low = digit n lit.
REQ-012 SHALL have port o_Seg, output, 7 bits: {g,f,e,d,c,b,a}, active-low.
REQ-013 SHALL have port o_Dp, output, 1 bit: decimal point, active-low.
REQ-014 SHALL have port o_FrameDone, output, 1 bit: one-cycle pulse per completed 4-digit frame.

Function
REQ-015 SHALL implement FSM states S_BLANK and S_SHOW with a slot counter and a 2-bit digit index.
REQ-016 SHALL go S_BLANK -> S_SHOW after exactly BLANK_CYCLES clocks in S_BLANK.
REQ-017 SHALL go S_SHOW -> S_BLANK after exactly SHOW_CYCLES clocks in S_SHOW, incrementing the index with wrap 3->0.
REQ-018 SHALL pulse o_FrameDone for one cycle on the edge where the index wraps 3->0.
REQ-019 SHALL register all outputs; outputs reflect the new state and index on the same edge as the transition.
REQ-020 SHALL drive o_Sel = index in both states.
REQ-021 SHALL drive o_Anodos = 4'b1111, o_Seg = 7'h7F and o_Dp = 1 in S_BLANK.
REQ-022 SHALL, in S_SHOW, clear only bit index of o_Anodos when i_DigitEn[index]=1, and otherwise keep 4'b1111; a disabled digit still consumes its slot time.
REQ-023 SHALL, in S_SHOW, drive o_Seg with the hex-to-7-segment decode of the active nibble (e.g. 0=1000000, 1=1111001, 8=0000000, F=0001110), and drive o_Dp = ~i_Dp[index].
REQ-024 SHALL capture i_Data into the shadow register on an accepted load, then drop o_Ready on the next edge.
REQ-025 SHALL ignore i_Load while o_Ready=0.
REQ-026 SHALL copy shadow -> active register on the frame-wrap edge (REQ-018) when a load is pending, then raise o_Ready on the same edge.
REQ-027 SHALL, for a load accepted on the frame-wrap edge, hold the data in shadow until the following frame wrap, because no pending load existed on that edge.
REQ-028 SHALL keep the active register frozen within a frame, so no mid-frame tearing occurs.

Reset
REQ-029 SHALL, with i_Reset=1 at any edge in any state, force S_BLANK, counter=0, index=0, active and shadow registers=0, pending=0.
REQ-030 SHALL hold these output values during reset: o_Sel=00, o_Anodos=1111, o_Seg=7'h7F, o_Dp=1, o_Ready=1, o_FrameDone=0.

Structure
REQ-031 SHALL place state encoding, ANODES_OFF=4'b1111, SEG_OFF=7'h7F and the 16-entry segment table in a shared package display_pkg.
REQ-032 SHALL implement the decode in one combinational sub-module, hex7seg: 4-bit in, 7-bit active-low out.

Verification (SHOW_CYCLES=4, BLANK_CYCLES=2; slot = 6 clocks, frame = 24 clocks)
REQ-033 SHALL verify: release reset, DigitEn=1111 -> o_Anodos 1111 x2, 1110 x4, 1111 x2, 1101 x4, ... 0111 x4, repeating; o_Sel steps 0,1,2,3,0.
REQ-034 SHALL verify: Load 16'h12AF mid-frame -> o_Ready=0 until wrap; next frame digit0 o_Seg=0001110 (F), digit3 o_Seg=1111001 (1); o_Ready=1 at wrap.
REQ-035 SHALL verify: second load 16'h5555 while o_Ready=0 -> ignored; the display shows 12AF.
REQ-036 SHALL verify: DigitEn=0101 -> digits 1 and 3 show o_Anodos=1111 through their slots; slot timing unchanged.
REQ-037 SHALL verify: reset asserted at cycle 2 of the digit-2 S_SHOW -> next edge gives the REQ-030 values; after release digit0 shows 1000000 (0).
REQ-038 SHALL verify: free run of 100 clocks -> o_FrameDone high exactly at clocks 24, 48, 72, 96 after reset release, each for one cycle.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 4-digit 7-segment scan controller.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [3:0] ANODES_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF    = 7'h7F;

    // Entry n holds the pattern for hex digit n; listed from F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0] i_Hex,
    output logic [6:0] o_Seg
);

    assign o_Seg = SEG_TABLE[i_Hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of four 7-segment digits with blanking between slots
// and a frame-synchronous shadow/active data register pair.
//
// state   | meaning
// S_BLANK | all anodes off for BLANK_CYCLES before the current digit slot
// S_SHOW  | digit r_idx driven for SHOW_CYCLES
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SHOW_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [15:0] i_Data,
    input  logic        i_Load,
    output logic        o_Ready,
    input  logic [3:0]  i_DigitEn,
    input  logic [3:0]  i_Dp,
    output logic [1:0]  o_Sel,
    output logic [3:0]  o_Anodos,
    output logic [6:0]  o_Seg,
    output logic        o_Dp,
    output logic        o_FrameDone
);

    localparam int MAX_C = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_TC  = CW'(SHOW_CYCLES - 1);

    scan_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_active;
    logic [15:0]   r_shadow;
    logic          r_pending;
    logic          r_ready;
    logic [1:0]    r_sel;
    logic [3:0]    r_anodos;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_done;

    logic       w_blank_done;
    logic       w_show_done;
    logic       w_wrap;
    logic       w_show_nx;
    logic [1:0] w_idx_nx;
    logic [3:0] w_nibble;
    logic [6:0] w_seg_dec;
    logic [3:0] w_an_show;

    assign w_blank_done = (r_state == S_BLANK) && (r_cnt == BLANK_TC);
    assign w_show_done  = (r_state == S_SHOW)  && (r_cnt == SHOW_TC);
    assign w_wrap       = w_show_done && (r_idx == 2'd3);
    assign w_idx_nx     = w_show_done ? r_idx + 2'd1 : r_idx;
    // The index does not change when the next state is S_SHOW, so r_idx selects it.
    assign w_show_nx    = w_blank_done || ((r_state == S_SHOW) && !w_show_done);
    assign w_an_show    = i_DigitEn[r_idx] ? ~(4'b0001 << r_idx) : ANODES_OFF;

    always_comb begin
        w_nibble = r_active[3:0];
        case (r_idx)
            2'd0:    w_nibble = r_active[3:0];
            2'd1:    w_nibble = r_active[7:4];
            2'd2:    w_nibble = r_active[11:8];
            default: w_nibble = r_active[15:12];
        endcase
    end

    hex7seg u_hex7seg (
        .i_Hex (w_nibble),
        .o_Seg (w_seg_dec)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state      <= S_BLANK;
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_active     <= 16'h0000;
            r_shadow     <= 16'h0000;
            r_pending    <= 1'b0;
            r_ready      <= 1'b1;
            r_sel        <= 2'd0;
            r_anodos     <= ANODES_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                S_BLANK: begin
                    if (w_blank_done) begin
                        r_state <= S_SHOW;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (w_show_done) begin
                        r_state <= S_BLANK;
                        r_cnt   <= '0;
                        r_idx   <= w_idx_nx;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_BLANK;
                    r_cnt   <= '0;
                end
            endcase

            r_sel        <= w_idx_nx;
            r_anodos     <= w_show_nx ? w_an_show : ANODES_OFF;
            r_seg        <= w_show_nx ? w_seg_dec : SEG_OFF;
            r_dp         <= w_show_nx ? ~i_Dp[r_idx] : 1'b1;
            r_frame_done <= w_wrap;

            // Ready implies nothing pending, so the copy and a new load never coincide.
            if (w_wrap && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
                r_ready   <= 1'b1;
            end
            if (i_Load && r_ready) begin
                r_shadow  <= i_Data;
                r_pending <= 1'b1;
                r_ready   <= 1'b0;
            end
        end
    end

    assign o_Ready     = r_ready;
    assign o_Sel       = r_sel;
    assign o_Anodos    = r_anodos;
    assign o_Seg       = r_seg;
    assign o_Dp        = r_dp;
    assign o_FrameDone = r_frame_done;

endmodule
